distram_delay_ctrl: RTL and testbench
=====================================

DISTRAM_DELAY_CTRL -- requirements
Module: distram_delay_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_DELAY, default 5: delay value loaded at reset.
REQ-002 SHALL have parameter MIN_DELAY, default 2: smallest legal delay value.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port dly_i, input, 5 bits: requested delay value D.
REQ-006 SHALL have port dly_valid_i, input, 1 bit: delay request valid.
REQ-007 SHALL have port dly_ready_o, output, 1 bit: controller can accept a request.
REQ-008 SHALL have port wraddr_o, output, 5 bits: RAM write address.
REQ-009 SHALL have port rdaddr_o, output, 5 bits: RAM read address.
REQ-010 SHALL have port we_o, output, 1 bit: RAM write enable.
REQ-011 SHALL have port dat_valid_o, output, 1 bit: the datapath's registered output holds a correctly delayed sample.
REQ-012 SHALL have port cur_dly_o, output, 5 bits: delay currently in effect.
REQ-013 SHALL have port err_o, output, 1 bit: one-cycle pulse when an illegal request is accepted.

Function
REQ-014 SHALL advance rdaddr_o and wraddr_o by 1 on every clock edge, mod 32, keeping wraddr_o = rdaddr_o + cur_dly_o (mod 32) in steady state.
REQ-015 SHALL hold we_o high on every cycle out of reset.
REQ-016 SHALL implement a two-state FSM with states FILL and RUN.
REQ-017 SHALL assert dly_ready_o only in RUN; a request is accepted on an edge where dly_valid_i && dly_ready_o.
REQ-018 On accepting a request with MIN_DELAY <= dly_i <= 31 and dly_i != cur_dly_o at edge t, SHALL set rdaddr_o <= rdaddr_o+1, wraddr_o <= rdaddr_o+1+dly_i, cur_dly_o <= dly_i, and state <= FILL.
REQ-019 On the same accepting edge t, SHALL drive dat_valid_o low.
REQ-020 SHALL stay in FILL and keep dat_valid_o low until edge t+D+1, where D is the new delay; at that edge it SHALL assert dat_valid_o and return to RUN.
REQ-021 SHALL treat an accepted request with dly_i == cur_dly_o as a no-op: no pointer jump, no state change, dat_valid_o unchanged, no err_o.
REQ-022 SHALL handle an accepted request with dly_i < MIN_DELAY as follows: pulse err_o for exactly one cycle (the cycle after edge t), leave delay, pointers and state unchanged, and keep dat_valid_o high.
REQ-023 SHALL ignore dly_valid_i during FILL; the requester holds its request until it is accepted.
REQ-024 SHALL count the FILL period with a 6-bit down-counter loaded with D+1, so that D=31 yields 32 blanked cycles without overflow.

Reset
REQ-025 While rst_i is asserted, asynchronously SHALL force rdaddr_o=0, wraddr_o=DEFAULT_DELAY, cur_dly_o=DEFAULT_DELAY, state=FILL, fill count=DEFAULT_DELAY+1, dat_valid_o=0, dly_ready_o=0, err_o=0, we_o=0.
REQ-026 After rst_i deasserts, SHALL raise we_o on the first edge and raise dat_valid_o and dly_ready_o on the (DEFAULT_DELAY+1)th edge.
REQ-027 Reset asserted mid-FILL or mid-request SHALL abandon the operation and apply REQ-025 values; no pending request survives reset.

Structure
REQ-028 SHALL place ADDR_BITS (5), the fill-counter width (6), and the FSM state enum (FILL, RUN) in shared package distram_delay_pkg.
REQ-029 SHALL instantiate one sub-module, distram_delay_addrgen, which contains the rd/wr pointer pair, with increment and load-with-offset controls.
REQ-030 SHALL be usable to drive the addresses of any number of 14-bit distributed-RAM delay lanes sharing one clock.

Verification
REQ-031 Reset release, DEFAULT_DELAY=5 -> we_o=1 from edge 1; dat_valid_o=1 and dly_ready_o=1 at edge 6; wraddr_o-rdaddr_o=5.
REQ-032 In RUN, request dly_i=12 accepted at edge t -> dat_valid_o=0 at t, =1 at t+13; cur_dly_o=12; ramp input appears at output 13 cycles later.
REQ-033 Request dly_i=1 -> err_o high for exactly one cycle; cur_dly_o, pointers and dat_valid_o unchanged.
REQ-034 Request dly_i equal to cur_dly_o -> accepted, no blanking, no err_o, pointer spacing unchanged.
REQ-035 Run 40 cycles with D=31 -> correct mod-32 wrap of both pointers; dat_valid_o low for exactly 32 cycles after the change.
REQ-036 Assert rst_i during FILL, 3 cycles into a D=20 change -> all outputs take REQ-025 values immediately, and the post-reset sequence of REQ-031 follows.

Source files
------------

// File: rtl/distram_delay_pkg.sv
// Shared widths and FSM encoding for the distributed-RAM delay-line controller.
package distram_delay_pkg;

  localparam int ADDR_BITS = 5;
  localparam int CNT_BITS  = 6;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/distram_delay_addrgen.sv
// Read/write pointer pair for a circular delay RAM: both advance every cycle,
// and a load re-spaces the write pointer to sit 'offset' entries ahead of the read.
module distram_delay_addrgen
  import distram_delay_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] RESET_OFFSET = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] offset,
  output logic [ADDR_BITS-1:0] rdaddr,
  output logic [ADDR_BITS-1:0] wraddr
);

  localparam logic [ADDR_BITS-1:0] ONE = ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] rd_next;

  assign rd_next = rdaddr + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdaddr <= '0;
      wraddr <= RESET_OFFSET;
    end else begin
      rdaddr <= rd_next;
      // Wrap-around arithmetic is the mod-32 ring behaviour of the RAM.
      wraddr <= load ? (rd_next + offset) : (wraddr + ONE);
    end
  end

endmodule

// File: rtl/distram_delay_ctrl.sv
// Delay-length controller for distributed-RAM delay lanes: owns the address
// pair, blanks the output while a new delay refills, and rejects too-short delays.
module distram_delay_ctrl
  import distram_delay_pkg::*;
#(
  parameter int DEFAULT_DELAY = 5,
  parameter int MIN_DELAY     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_BITS-1:0] dly_i,
  input  logic                 dly_valid_i,
  output logic                 dly_ready_o,
  output logic [ADDR_BITS-1:0] wraddr_o,
  output logic [ADDR_BITS-1:0] rdaddr_o,
  output logic                 we_o,
  output logic                 dat_valid_o,
  output logic [ADDR_BITS-1:0] cur_dly_o,
  output logic                 err_o
);

  localparam logic [ADDR_BITS-1:0] DEF_D   = ADDR_BITS'(DEFAULT_DELAY);
  localparam logic [ADDR_BITS-1:0] MIN_D   = ADDR_BITS'(MIN_DELAY);
  localparam logic [CNT_BITS-1:0]  DEF_CNT = CNT_BITS'(DEFAULT_DELAY + 1);
  localparam logic [CNT_BITS-1:0]  CNT_ONE = CNT_BITS'(1);

  state_e               state;
  logic [CNT_BITS-1:0]  fill_cnt;
  logic [ADDR_BITS-1:0] cur_dly;
  logic                 accept;
  logic                 illegal;
  logic                 change;

  assign dly_ready_o = (state == RUN);
  assign accept      = dly_valid_i && dly_ready_o;
  assign illegal     = (dly_i < MIN_D);
  assign change      = accept && !illegal && (dly_i != cur_dly);
  assign cur_dly_o   = cur_dly;

  distram_delay_addrgen #(
    .RESET_OFFSET (DEF_D)
  ) u_addrgen (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (change),
    .offset (dly_i),
    .rdaddr (rdaddr_o),
    .wraddr (wraddr_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= FILL;
      fill_cnt    <= DEF_CNT;
      cur_dly     <= DEF_D;
      dat_valid_o <= 1'b0;
      err_o       <= 1'b0;
      we_o        <= 1'b0;
    end else begin
      we_o  <= 1'b1;
      err_o <= accept && illegal;
      if (change) begin
        // Counter is one bit wider than the delay so D=31 loads 32 cleanly.
        cur_dly     <= dly_i;
        state       <= FILL;
        fill_cnt    <= {1'b0, dly_i} + CNT_ONE;
        dat_valid_o <= 1'b0;
      end else if (state == FILL) begin
        if (fill_cnt == CNT_ONE) begin
          state       <= RUN;
          dat_valid_o <= 1'b1;
        end else begin
          fill_cnt <= fill_cnt - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_distram_delay_ctrl.sv
// Randomized bench for distram_delay_ctrl: drives one 14-bit RAM lane with a ramp
// and compares all outputs against an edge-count/delay-history reference model.
module tb_distram_delay_ctrl;

  localparam int DEF = 5;
  localparam int MIN = 2;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] dly_i;
  logic       dly_valid_i;
  logic       dly_ready_o;
  logic [4:0] wraddr_o;
  logic [4:0] rdaddr_o;
  logic       we_o;
  logic       dat_valid_o;
  logic [4:0] cur_dly_o;
  logic       err_o;

  always #5 clk = ~clk;

  distram_delay_ctrl #(
    .DEFAULT_DELAY (DEF),
    .MIN_DELAY     (MIN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .dly_i       (dly_i),
    .dly_valid_i (dly_valid_i),
    .dly_ready_o (dly_ready_o),
    .wraddr_o    (wraddr_o),
    .rdaddr_o    (rdaddr_o),
    .we_o        (we_o),
    .dat_valid_o (dat_valid_o),
    .cur_dly_o   (cur_dly_o),
    .err_o       (err_o)
  );

  // One delay lane driven by the controller's addresses.
  logic [13:0] mem [32];
  logic [13:0] dout;
  logic [13:0] din;

  always @(posedge clk) begin
    if (we_o) mem[wraddr_o] <= din;
    dout <= mem[rdaddr_o];
  end

  // Reference model state: edges since reset release, delay in force,
  // edge of the last delay change, and the first edge of valid writes.
  int j, cur, t_chg, epoch;
  bit exp_ready, exp_err;
  bit pending;
  int pend_dly;
  int hist [4096];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    j         = 0;
    cur       = DEF;
    t_chg     = 0;
    epoch     = 1;
    exp_ready = 0;
    exp_err   = 0;
    pending   = 0;
  endtask

  task automatic check_reset_values();
    chk("rst_rdaddr", rdaddr_o, 0);
    chk("rst_wraddr", wraddr_o, DEF);
    chk("rst_cur_dly", cur_dly_o, DEF);
    chk("rst_dat_valid", dat_valid_o, 0);
    chk("rst_ready", dly_ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_we", we_o, 0);
  endtask

  task automatic step();
    bit acc;
    @(posedge clk);
    j++;
    hist[j % 4096] = din;
    acc     = dly_valid_i && exp_ready;
    exp_err = 0;
    if (acc) begin
      pending = 0;
      if (dly_i < MIN) exp_err = 1;
      else if (int'(dly_i) != cur) begin
        cur   = dly_i;
        t_chg = j;
        epoch = j;
      end
    end
    exp_ready = (j >= t_chg + cur + 1);
    @(negedge clk);
    chk("rdaddr", rdaddr_o, j % 32);
    chk("wraddr", wraddr_o, (j + cur) % 32);
    chk("cur_dly", cur_dly_o, cur);
    chk("dat_valid", dat_valid_o, exp_ready);
    chk("dly_ready", dly_ready_o, exp_ready);
    chk("we", we_o, 1);
    chk("err", err_o, exp_err);
    if (exp_ready && (j - cur >= epoch + 1))
      chk("dout", dout, hist[(j - cur) % 4096]);
    dly_valid_i = pending;
    dly_i       = pending ? 5'(pend_dly) : 5'd0;
    din         = din + 14'd1;
  endtask

  task automatic post(input int d);
    pending     = 1;
    pend_dly    = d;
    dly_valid_i = 1'b1;
    dly_i       = 5'(d);
  endtask

  task automatic request(input int d, input int hold_after);
    post(d);
    for (int k = 0; k < 64 && pending; k++) step();
    chk("req_accepted_pending", pending, 0);
    pending     = 0;
    dly_valid_i = 1'b0;
    repeat (hold_after) step();
  endtask

  // Called at a falling edge: reset asserted between edges, checked before the next edge.
  task automatic do_reset();
    #2 rst_i = 1'b1;
    #1 check_reset_values();
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_i = 1'b0;
    model_reset();
    dly_valid_i = 1'b0;
    dly_i       = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    rst_i       = 1'b1;
    dly_valid_i = 1'b0;
    dly_i       = 5'd0;
    din         = 14'd0;
    #12 check_reset_values();
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    repeat (8) step();

    request(12, 16);
    request(1, 4);
    request(12, 4);
    request(31, 40);
    request(20, 0);
    repeat (3) step();
    do_reset();
    repeat (10) step();

    for (int n = 0; n < 1500; n++) begin
      if (!pending && $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0:       d = $urandom_range(0, MIN - 1);
          1:       d = cur;
          2:       d = 31;
          default: d = $urandom_range(0, 31);
        endcase
        post(d);
      end
      step();
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
